// File: rtl/alu_regfile_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_regfile_core
// Purpose  : Execute-datapath core of the 24-bit-instruction / 32-bit-data
//            CPU: a 16 x 32-bit register file (one byte-enabled synchronous
//            write port, two asynchronous read ports) beside a purely
//            combinational 32-bit ALU / barrel shifter.
// Ports    :
//   i_clk, i_rst          rising-edge clock, async active-high reset (RF only)
//   i_clk_en, i_cs_b      write qualifiers (enable high, chip-select low)
//   i_waddr, i_wen, i_din write address, per-byte enables, write data
//   i_raddr_0/1, o_dout_0/1  asynchronous read ports (no write bypass)
//   i_din_a, i_din_b      ALU operands (b also supplies the shift amount)
//   i_cin, i_vin          incoming carry / overflow flags
//   i_opcode              6-bit ALU opcode (unlisted codes pass b through)
//   o_alu_dout, o_cout, o_vout  ALU result and flags
//   o_mcp                 high for MUL: result may take two clock periods
// Revision : 1.0  initial release
// ============================================================================
module alu_regfile_core (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clk_en,
  input  logic        i_cs_b,
  input  logic [3:0]  i_waddr,
  input  logic [3:0]  i_wen,
  input  logic [31:0] i_din,
  input  logic [3:0]  i_raddr_0,
  input  logic [3:0]  i_raddr_1,
  output logic [31:0] o_dout_0,
  output logic [31:0] o_dout_1,
  input  logic [31:0] i_din_a,
  input  logic [31:0] i_din_b,
  input  logic        i_cin,
  input  logic        i_vin,
  input  logic [5:0]  i_opcode,
  output logic [31:0] o_alu_dout,
  output logic        o_cout,
  output logic        o_vout,
  output logic        o_mcp
);

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100001;
  localparam logic [5:0] OP_AND  = 6'b100010;
  localparam logic [5:0] OP_OR   = 6'b100011;
  localparam logic [5:0] OP_XOR  = 6'b100100;
  localparam logic [5:0] OP_LSL  = 6'b100101;
  localparam logic [5:0] OP_LSR  = 6'b100110;
  localparam logic [5:0] OP_ASR  = 6'b100111;
  localparam logic [5:0] OP_ADC  = 6'b101000;
  localparam logic [5:0] OP_SBC  = 6'b101001;
  localparam logic [5:0] OP_ROR  = 6'b101010;
  localparam logic [5:0] OP_MUL  = 6'b101011;
  localparam logic [5:0] OP_MOVT = 6'b011100;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [31:0] rf_q [16];
  logic [31:0] wr_word_d;
  logic        wr_go;

  assign wr_go = i_clk_en & ~i_cs_b;

  // Merge the enabled bytes of i_din into the current contents of the target
  // register so disabled bytes are preserved.
  always_comb begin
    wr_word_d = rf_q[i_waddr];
    for (int n = 0; n < 4; n++) begin
      if (i_wen[n]) wr_word_d[8*n +: 8] = i_din[8*n +: 8];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (wr_go) begin
      rf_q[i_waddr] <= wr_word_d;
    end
  end

  // Reads see the registered value only: a same-cycle write is not bypassed.
  assign o_dout_0 = rf_q[i_raddr_0];
  assign o_dout_1 = rf_q[i_raddr_1];

  // --------------------------------------------------------------------------
  // ALU / barrel shifter
  // --------------------------------------------------------------------------
  logic [4:0]  sh_amt;
  logic        sh_zero;
  logic        is_sub;
  logic        add_cin;
  logic [31:0] add_b;
  logic [32:0] add_sum;
  logic [32:0] lsl_t;
  logic [32:0] lsr_t;
  logic [32:0] asr_t;
  logic [63:0] ror_t;

  assign sh_amt  = i_din_b[4:0];
  assign sh_zero = (sh_amt == 5'd0);

  // One adder serves ADD/SUB/ADC/SBC: subtraction inverts b, and the
  // carry-in is the constant 0/1 or the incoming carry flag.
  assign is_sub  = (i_opcode == OP_SUB) || (i_opcode == OP_SBC);
  assign add_b   = is_sub ? ~i_din_b : i_din_b;
  assign add_cin = ((i_opcode == OP_ADC) || (i_opcode == OP_SBC)) ? i_cin : is_sub;
  assign add_sum = {1'b0, i_din_a} + {1'b0, add_b} + {32'd0, add_cin};

  // Shifts are widened by one bit so the last bit shifted out lands in the
  // extra position (bit 32 for left, bit 0 for right shifts).
  assign lsl_t = {1'b0, i_din_a} << sh_amt;
  assign lsr_t = {i_din_a, 1'b0} >> sh_amt;
  assign asr_t = $unsigned($signed({i_din_a, 1'b0}) >>> sh_amt);
  assign ror_t = {i_din_a, i_din_a} >> sh_amt;

  always_comb begin
    o_alu_dout = i_din_b;
    o_cout     = i_cin;
    o_vout     = i_vin;
    o_mcp      = 1'b0;
    case (i_opcode)
      OP_ADD, OP_ADC: begin
        o_alu_dout = add_sum[31:0];
        o_cout     = add_sum[32];
        o_vout     = (i_din_a[31] == i_din_b[31]) && (add_sum[31] != i_din_a[31]);
      end
      OP_SUB, OP_SBC: begin
        o_alu_dout = add_sum[31:0];
        o_cout     = add_sum[32];
        o_vout     = (i_din_a[31] != i_din_b[31]) && (add_sum[31] != i_din_a[31]);
      end
      OP_AND: o_alu_dout = i_din_a & i_din_b;
      OP_OR:  o_alu_dout = i_din_a | i_din_b;
      OP_XOR: o_alu_dout = i_din_a ^ i_din_b;
      OP_LSL: begin
        o_alu_dout = lsl_t[31:0];
        if (!sh_zero) o_cout = lsl_t[32];
      end
      OP_LSR: begin
        o_alu_dout = lsr_t[32:1];
        if (!sh_zero) o_cout = lsr_t[0];
      end
      OP_ASR: begin
        o_alu_dout = asr_t[32:1];
        if (!sh_zero) o_cout = asr_t[0];
      end
      OP_ROR: begin
        o_alu_dout = ror_t[31:0];
        if (!sh_zero) o_cout = ror_t[31];
      end
      OP_MUL: begin
        o_alu_dout = i_din_a * i_din_b;
        o_mcp      = 1'b1;
      end
      OP_MOVT: o_alu_dout = {i_din_b[15:0], 16'h0000};
      default: o_alu_dout = i_din_b;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_regfile_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_regfile_core
// Purpose  : Directed self-checking bench for alu_regfile_core; expected
//            values are hand-computed constants.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_regfile_core;

  logic        i_clk;
  logic        i_rst;
  logic        i_clk_en;
  logic        i_cs_b;
  logic [3:0]  i_waddr;
  logic [3:0]  i_wen;
  logic [31:0] i_din;
  logic [3:0]  i_raddr_0;
  logic [3:0]  i_raddr_1;
  logic [31:0] o_dout_0;
  logic [31:0] o_dout_1;
  logic [31:0] i_din_a;
  logic [31:0] i_din_b;
  logic        i_cin;
  logic        i_vin;
  logic [5:0]  i_opcode;
  logic [31:0] o_alu_dout;
  logic        o_cout;
  logic        o_vout;
  logic        o_mcp;

  int n_vec;
  int n_err;

  alu_regfile_core dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clk_en   (i_clk_en),
    .i_cs_b     (i_cs_b),
    .i_waddr    (i_waddr),
    .i_wen      (i_wen),
    .i_din      (i_din),
    .i_raddr_0  (i_raddr_0),
    .i_raddr_1  (i_raddr_1),
    .o_dout_0   (o_dout_0),
    .o_dout_1   (o_dout_1),
    .i_din_a    (i_din_a),
    .i_din_b    (i_din_b),
    .i_cin      (i_cin),
    .i_vin      (i_vin),
    .i_opcode   (i_opcode),
    .o_alu_dout (o_alu_dout),
    .o_cout     (o_cout),
    .o_vout     (o_vout),
    .o_mcp      (o_mcp)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One register-file write cycle; inputs change on the falling edge.
  task automatic rf_write(input logic [3:0] addr, input logic [3:0] wen,
                          input logic [31:0] din, input logic cs_b, input logic clk_en);
    @(negedge i_clk);
    i_waddr  = addr;
    i_wen    = wen;
    i_din    = din;
    i_cs_b   = cs_b;
    i_clk_en = clk_en;
    @(posedge i_clk);
    #1;
    i_cs_b   = 1'b1;
    i_clk_en = 1'b0;
  endtask

  task automatic alu(input string tag, input logic [5:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic cin, input logic vin,
                     input logic [31:0] exp_d, input logic exp_c, input logic exp_v,
                     input logic exp_m);
    i_opcode = op;
    i_din_a  = a;
    i_din_b  = b;
    i_cin    = cin;
    i_vin    = vin;
    #1;
    chk({tag, ".dout"}, o_alu_dout, exp_d);
    chk({tag, ".cout"}, {31'd0, o_cout}, {31'd0, exp_c});
    chk({tag, ".vout"}, {31'd0, o_vout}, {31'd0, exp_v});
    chk({tag, ".mcp"},  {31'd0, o_mcp},  {31'd0, exp_m});
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    i_rst     = 1'b1;
    i_clk_en  = 1'b0;
    i_cs_b    = 1'b1;
    i_waddr   = 4'd0;
    i_wen     = 4'd0;
    i_din     = 32'd0;
    i_raddr_0 = 4'd3;
    i_raddr_1 = 4'd5;
    i_din_a   = 32'd0;
    i_din_b   = 32'd0;
    i_cin     = 1'b0;
    i_vin     = 1'b0;
    i_opcode  = 6'b000000;

    // Reset state
    #2;
    chk("reset_dout0", o_dout_0, 32'h0);
    chk("reset_dout1", o_dout_1, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Write R3, then asynchronous reset clears it without a clock edge
    rf_write(4'd3, 4'b1111, 32'h12345678, 1'b0, 1'b1);
    chk("r3_written", o_dout_0, 32'h12345678);
    @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    chk("r3_async_reset", o_dout_0, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Byte-enabled writes to R5
    rf_write(4'd5, 4'b1111, 32'hAABBCCDD, 1'b0, 1'b1);
    chk("r5_full", o_dout_1, 32'hAABBCCDD);
    rf_write(4'd5, 4'b0101, 32'h11223344, 1'b0, 1'b1);
    chk("r5_bytes", o_dout_1, 32'hAA22CC44);
    rf_write(4'd5, 4'b1111, 32'h00000000, 1'b1, 1'b1);
    chk("r5_cs_b_high", o_dout_1, 32'hAA22CC44);
    rf_write(4'd5, 4'b1111, 32'h00000000, 1'b0, 1'b0);
    chk("r5_clk_en_low", o_dout_1, 32'hAA22CC44);
    rf_write(4'd5, 4'b0000, 32'h00000000, 1'b0, 1'b1);
    chk("r5_wen_zero", o_dout_1, 32'hAA22CC44);
    i_raddr_0 = 4'd3;
    #1;
    chk("r3_untouched", o_dout_0, 32'h0);

    // Same-cycle read/write of R7 on both ports: no bypass
    @(negedge i_clk);
    i_raddr_0 = 4'd7;
    i_raddr_1 = 4'd7;
    i_waddr   = 4'd7;
    i_wen     = 4'b1111;
    i_din     = 32'h00000055;
    i_cs_b    = 1'b0;
    i_clk_en  = 1'b1;
    #1;
    chk("r7_old_p0", o_dout_0, 32'h0);
    chk("r7_old_p1", o_dout_1, 32'h0);
    @(posedge i_clk);
    #1;
    i_cs_b   = 1'b1;
    i_clk_en = 1'b0;
    chk("r7_new_p0", o_dout_0, 32'h55);
    chk("r7_new_p1", o_dout_1, 32'h55);

    // Arithmetic
    alu("add_ovf",   6'b100000, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    alu("add_wrap",  6'b100000, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    alu("sub_neg",   6'b100001, 32'h5,        32'h7, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    alu("sub_eq",    6'b100001, 32'h9,        32'h9, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    alu("sub_ovf",   6'b100001, 32'h80000000, 32'h1, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    alu("adc",       6'b101000, 32'h1,        32'h1, 1'b1, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0);
    alu("sbc",       6'b101001, 32'h5,        32'h3, 1'b0, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0);

    // Logic
    alu("and", 6'b100010, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b0, 32'hF000F000, 1'b1, 1'b0, 1'b0);
    alu("or",  6'b100011, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b1, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0);
    alu("xor", 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0);

    // Shifts
    alu("lsr_1",    6'b100110, 32'h80000001, 32'd1,  1'b0, 1'b1, 32'h40000000, 1'b1, 1'b1, 1'b0);
    alu("asr_31",   6'b100111, 32'h80000000, 32'd31, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    alu("ror_1",    6'b101010, 32'h00000001, 32'd1,  1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0);
    alu("ror_8",    6'b101010, 32'h12345678, 32'd8,  1'b1, 1'b0, 32'h78123456, 1'b0, 1'b0, 1'b0);
    alu("lsl_0",    6'b100101, 32'h00000123, 32'd0,  1'b1, 1'b0, 32'h00000123, 1'b1, 1'b0, 1'b0);
    alu("lsl_1",    6'b100101, 32'h80000001, 32'd1,  1'b0, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0);
    alu("lsl_4",    6'b100101, 32'h0000000F, 32'd4,  1'b1, 1'b0, 32'h000000F0, 1'b0, 1'b0, 1'b0);
    alu("lsl_b32",  6'b100101, 32'h0000000F, 32'd32, 1'b0, 1'b0, 32'h0000000F, 1'b0, 1'b0, 1'b0);

    // MUL / MOVT / PASS
    alu("mul_wrap", 6'b101011, 32'h00010000, 32'h00010000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    alu("mul_3x5",  6'b101011, 32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'h0000000F, 1'b0, 1'b1, 1'b1);
    alu("movt",     6'b011100, 32'hFFFFFFFF, 32'hFFFF1234, 1'b0, 1'b0, 32'h12340000, 1'b0, 1'b0, 1'b0);
    alu("pass_0",   6'b000000, 32'h12345678, 32'h0000DEAD, 1'b1, 1'b0, 32'h0000DEAD, 1'b1, 1'b0, 1'b0);
    alu("pass_2c",  6'b101100, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_regfile_core.md
Name: alu_regfile_core

Overview:
- Execute-datapath core of the 24-bit-instruction / 32-bit-data CPU.
- Contains a 16 x 32-bit general register file: one byte-enabled synchronous write port and two asynchronous read ports.
- Contains a purely combinational 32-bit ALU/barrel shifter producing result, carry, overflow and a multi-cycle-path flag.
- The pipeline feeds RF read data into the ALU operands and writes ALU/load results back.

Parameters:
- none (data width 32, 16 registers, opcode width 6: all fixed)

Ports:
- i_clk  in  1  clock; rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_clk_en  in  1  global clock enable for the RF write
- i_cs_b  in  1  RF write chip-select, active-low
- i_waddr  in  4  RF write address
- i_wen  in  4  per-byte write enables; bit n covers din[8n+7:8n]
- i_din  in  32  RF write data
- i_raddr_0  in  4  read port 0 address
- i_raddr_1  in  4  read port 1 address
- o_dout_0  out  32  read port 0 data
- o_dout_1  out  32  read port 1 data
- i_din_a  in  32  ALU operand A
- i_din_b  in  32  ALU operand B / shift amount
- i_cin  in  1  current carry flag
- i_vin  in  1  current overflow flag
- i_opcode  in  6  ALU opcode
- o_alu_dout  out  32  ALU result
- o_cout  out  1  carry out
- o_vout  out  1  overflow out
- o_mcp  out  1  multi-cycle-path request

Behaviour:
- Reset (i_rst=1, asynchronous): all 16 registers become 0, so o_dout_0 and o_dout_1 read 0. ALU outputs are combinational and have no reset.
- RF write: on the rising edge of i_clk with i_clk_en=1 and i_cs_b=0, each byte n of reg[i_waddr] with i_wen[n]=1 takes i_din byte n. Bytes with i_wen[n]=0 are preserved.
- Write with i_wen=0000 is a no-op. Writes are ignored while i_rst=1.
- RF read: o_dout_k = reg[i_raddr_k], combinational. No write-through bypass: a read of the address being written returns the old value until after the edge.
- Both ports may read the same address simultaneously.
- ALU opcodes (all other codes are PASS):
  - 100000 ADD: dout=a+b; cout=carry out of bit 31; vout = a[31]==b[31] && dout[31]!=a[31]
  - 100001 SUB: dout = a + ~b + 1; cout=carry out (1 = no borrow); vout = a[31]!=b[31] && dout[31]!=a[31]
  - 100010 AND, 100011 OR, 100100 XOR: bitwise; cout=cin, vout=vin
  - 100101 LSL, 100110 LSR, 100111 ASR: shift a by b[4:0]
    - cout = last bit shifted out; cout=cin when the amount is 0
    - vout=vin
  - 101000 ADC, 101001 SBC: as ADD/SUB with cin replacing the constant carry-in 0/1
  - 101010 ROR: rotate a right by b[4:0]; cout = dout[31] when the amount is nonzero, else cin
  - 101011 MUL: dout = low 32 bits of a*b; cout=cin, vout=vin; o_mcp=1
  - 011100 MOVT: dout = {b[15:0],16'h0}; cout=cin, vout=vin
  - PASS (loads, stores, branches, jumps, MOV-immediate): dout=b; cout=cin, vout=vin
- o_mcp is 1 only for MUL, combinationally. The consuming pipeline holds operands for two cycles, so the MUL path may take two clock periods.
- The ALU is fully combinational: zero-cycle latency, no internal state.
- Boundary requirements:
  - 0xFFFFFFFF+1 gives 0 with cout=1.
  - 0x7FFFFFFF+1 gives 0x80000000 with vout=1.
  - SUB of equal operands gives 0 with cout=1.
  - Shift amounts use only b[4:0] (b=32 behaves as a shift of 0).

Test Plan:
- Reset: assert i_rst mid-run after writing R3=0x12345678 -> o_dout_0 (raddr 3) reads 0 immediately, without a clock edge.
- Byte-enable write:
  - Write R5=0xAABBCCDD with wen=1111, then 0x11223344 with wen=0101 -> R5=0xAA22CC44.
  - cs_b=1 or clk_en=0 leaves R5 unchanged.
- Read/write same cycle: write R7=0x55 while reading R7 on both ports -> old value before the edge, 0x55 after, on both ports.
- Arithmetic:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, v=1, c=0.
  - ADD 0xFFFFFFFF+1 -> 0, c=1.
  - SUB 5-7 -> 0xFFFFFFFE, c=0.
  - ADC 1+1 with cin=1 -> 3.
- Shifts:
  - LSR 0x80000001 by 1 -> 0x40000000, c=1.
  - ASR 0x80000000 by 31 -> 0xFFFFFFFF.
  - ROR 0x1 by 1 -> 0x80000000, c=1.
  - LSL by 0 -> c=cin.
- MUL/MOVT/PASS:
  - MUL 0x10000 x 0x10000 -> 0, o_mcp=1.
  - MOVT b=0x1234 -> 0x12340000.
  - Opcode 000000 with b=0xDEAD -> dout=0xDEAD, c/v echo cin/vin, o_mcp=0.
